// File: rtl/resnet_residual_add.sv
// Residual-join stage for a ResNet basic block.
// Buffers the skip-path stream in a FIFO (optionally decimated 2x in rows and
// columns), pairs each main-path beat with the oldest buffered skip word, and
// emits the saturated (optionally ReLU-clamped) sum one cycle later.
//
// Handshake: both input streams are valid-only with no ready. A beat is taken
// on every rising edge where its valid is high; the main path is never
// stalled. valid_out is high for exactly one cycle per accepted main beat.
module resnet_residual_add #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int CHANNEL_NUM  = 64,
  parameter int FIFO_DEPTH   = 1024,
  parameter int RELU_EN      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in_no1,
  input  logic [DATA_WIDTH-1:0]         in_no1,
  input  logic                          valid_in_no2,
  input  logic [DATA_WIDTH-1:0]         in_no2,
  input  logic                          stride2,
  output logic [DATA_WIDTH-1:0]         pxl_out,
  output logic                          valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_overflow,
  output logic                          err_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int HW = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [HW-1:0] CH_LAST  = HW'(CHANNEL_NUM - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] ch;
  logic          stride_r;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic                  frame_start;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  overflow_evt;
  logic                  underflow_evt;
  logic [DATA_WIDTH-1:0] skip_operand;
  logic [DATA_WIDTH:0]   wide_sum;
  logic [DATA_WIDTH-1:0] result;

  // Skip-stream raster position: col -> row -> channel, wrapping at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (valid_in_no2) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          ch  <= (ch == CH_LAST) ? '0 : ch + HW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stride mode is latched only while idle at a frame boundary, so a frame
  // is decimated consistently even if stride2 toggles part-way through.
  always_ff @(posedge clk) begin
    if (reset) begin
      stride_r <= 1'b0;
    end else if (frame_start && !valid_in_no2) begin
      stride_r <= stride2;
    end
  end

  // Push/pop decode, bypass selection and saturating/ReLU arithmetic.
  always_comb begin
    frame_start   = (col == '0) && (row == '0) && (ch == '0);
    push          = valid_in_no2 && (!stride_r || (!col[0] && !row[0]));
    pop           = valid_in_no1;
    fifo_empty    = (fifo_count == '0);
    fifo_full     = (fifo_count == CNT_FULL);
    // An empty FIFO with push and pop together is a straight bypass; a full
    // FIFO only accepts a write when a read frees a slot the same cycle.
    wr_en         = push && !(fifo_empty && pop) && !(fifo_full && !pop);
    rd_en         = pop && !fifo_empty;
    overflow_evt  = push && fifo_full && !pop;
    underflow_evt = pop && fifo_empty && !push;

    skip_operand = '0;
    if (!fifo_empty) begin
      skip_operand = mem[rd_ptr];
    end else if (push) begin
      skip_operand = in_no2;
    end

    wide_sum = {in_no1[DATA_WIDTH-1], in_no1} + {skip_operand[DATA_WIDTH-1], skip_operand};
    if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
      result = wide_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      result = wide_sum[DATA_WIDTH-1:0];
    end
    if ((RELU_EN != 0) && result[DATA_WIDTH-1]) begin
      result = '0;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_no2;
    end
  end

  // FIFO pointers and occupancy; pointer width wraps at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // One-cycle output register; pxl_out holds between valid beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) pxl_out <= result;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (overflow_evt)  err_overflow  <= 1'b1;
      if (underflow_evt) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_resnet_residual_add.sv
// Directed bench for resnet_residual_add. Two instances share one stimulus:
// u_relu (ReLU on, 8-entry FIFO) and u_lin (ReLU off, 4-entry FIFO), both on a
// 4x4x2 frame so decimation and overflow cases stay short.
module tb_resnet_residual_add;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v1 = 1'b0;
  logic [31:0] d1 = '0;
  logic        v2 = 1'b0;
  logic [31:0] d2 = '0;
  logic        stride2 = 1'b0;

  logic [31:0] r_pxl;
  logic        r_valid;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  logic        r_unf;

  logic [31:0] l_pxl;
  logic        l_valid;
  logic [2:0]  l_cnt;
  logic        l_ovf;
  logic        l_unf;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  resnet_residual_add #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(2),
    .FIFO_DEPTH(8), .RELU_EN(1)
  ) u_relu (
    .clk(clk), .reset(reset),
    .valid_in_no1(v1), .in_no1(d1),
    .valid_in_no2(v2), .in_no2(d2),
    .stride2(stride2),
    .pxl_out(r_pxl), .valid_out(r_valid), .fifo_count(r_cnt),
    .err_overflow(r_ovf), .err_underflow(r_unf)
  );

  resnet_residual_add #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(2),
    .FIFO_DEPTH(4), .RELU_EN(0)
  ) u_lin (
    .clk(clk), .reset(reset),
    .valid_in_no1(v1), .in_no1(d1),
    .valid_in_no2(v2), .in_no2(d2),
    .stride2(stride2),
    .pxl_out(l_pxl), .valid_out(l_valid), .fifo_count(l_cnt),
    .err_overflow(l_ovf), .err_underflow(l_unf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic beat(input logic a, input logic [31:0] da, input logic b, input logic [31:0] db);
    v1 = a; d1 = da; v2 = b; d2 = db;
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic do_reset();
    v1 = 1'b0; v2 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_r_pxl"},   r_pxl,   32'd0);
    check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    check({tag, "_r_cnt"},   32'(r_cnt), 32'd0);
    check({tag, "_r_flags"}, 32'({r_ovf, r_unf}), 32'd0);
    check({tag, "_l_cnt"},   32'(l_cnt), 32'd0);
    check({tag, "_l_flags"}, 32'({l_ovf, l_unf}), 32'd0);
  endtask

  initial begin
    logic [31:0] lin_exp [8];

    // Reset
    @(posedge clk); #1;
    do_reset();
    check_reset_state("rst0");

    // Buffered pairing: skips 5,-3,7 then three main beats of 10.
    beat(0, 0, 1, 32'd5);
    check("t1_cnt1", 32'(r_cnt), 32'd1);
    beat(0, 0, 1, -32'sd3);
    beat(0, 0, 1, 32'd7);
    check("t1_cnt3_r", 32'(r_cnt), 32'd3);
    check("t1_cnt3_l", 32'(l_cnt), 32'd3);
    check("t1_novalid", 32'(r_valid), 32'd0);
    beat(1, 32'd10, 0, 0);
    check("t1_v0", 32'(r_valid), 32'd1);
    check("t1_p0", r_pxl, 32'd15);
    check("t1_c0", 32'(r_cnt), 32'd2);
    beat(1, 32'd10, 0, 0);
    check("t1_p1", r_pxl, 32'd7);
    check("t1_p1_l", l_pxl, 32'd7);
    beat(1, 32'd10, 0, 0);
    check("t1_p2", r_pxl, 32'd17);
    check("t1_c2", 32'(r_cnt), 32'd0);
    beat(0, 0, 0, 0);
    check("t1_idle_v", 32'(r_valid), 32'd0);
    check("t1_hold", r_pxl, 32'd17);

    // Bypass with FIFO empty: 4 + -9.
    beat(1, -32'sd9, 1, 32'd4);
    check("t2_relu", r_pxl, 32'd0);
    check("t2_lin", l_pxl, 32'hFFFF_FFFB);
    check("t2_cnt", 32'(r_cnt), 32'd0);
    check("t2_unf", 32'(r_unf), 32'd0);

    // Saturation at both ends.
    beat(1, 32'h7FFF_FFF0, 1, 32'h0000_0100);
    check("t3_pos_r", r_pxl, 32'h7FFF_FFFF);
    check("t3_pos_l", l_pxl, 32'h7FFF_FFFF);
    beat(1, 32'h8000_0000, 1, 32'hFFFF_FFFF);
    check("t3_neg_l", l_pxl, 32'h8000_0000);
    check("t3_neg_r", r_pxl, 32'd0);

    // Stride-2 decimation over a full 4x4x2 frame.
    do_reset();
    stride2 = 1'b1;
    beat(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) beat(0, 0, 1, 32'(i));
    check("t4_cnt_r", 32'(r_cnt), 32'd8);
    check("t4_cnt_l", 32'(l_cnt), 32'd4);
    check("t4_ovf_l", 32'(l_ovf), 32'd1);
    check("t4_ovf_r", 32'(r_ovf), 32'd0);
    exp_q = '{32'd0, 32'd2, 32'd8, 32'd10, 32'd16, 32'd18, 32'd24, 32'd26};
    lin_exp = '{32'd0, 32'd2, 32'd8, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      beat(1, 32'd0, 0, 0);
      check($sformatf("t4_r%0d", i), r_pxl, exp_q.pop_front());
      check($sformatf("t4_l%0d", i), l_pxl, lin_exp[i]);
    end
    check("t4_unf_l", 32'(l_unf), 32'd1);
    check("t4_unf_r", 32'(r_unf), 32'd0);

    // Overflow then underflow without stride.
    do_reset();
    stride2 = 1'b0;
    beat(0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) beat(0, 0, 1, 32'(i));
    check("t5_cnt_l", 32'(l_cnt), 32'd4);
    check("t5_ovf_l", 32'(l_ovf), 32'd1);
    check("t5_cnt_r", 32'(r_cnt), 32'd5);
    check("t5_ovf_r", 32'(r_ovf), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      beat(1, 32'd100, 0, 0);
      check($sformatf("t5_r%0d", i), r_pxl, 32'(100 + i));
      check($sformatf("t5_l%0d", i), l_pxl, (i == 5) ? 32'd100 : 32'(100 + i));
    end
    check("t5_unf_l", 32'(l_unf), 32'd1);
    check("t5_unf_r", 32'(r_unf), 32'd0);

    // Mid-plane reset with 3 buffered words; stride2 raised mid-frame.
    beat(0, 0, 1, 32'd10);
    stride2 = 1'b1;
    beat(0, 0, 1, 32'd11);
    beat(0, 0, 1, 32'd12);
    check("t6_cnt_pre", 32'(l_cnt), 32'd3);
    check("t6_cnt_pre_r", 32'(r_cnt), 32'd3);
    do_reset();
    check_reset_state("t6_rst");
    check("t6_l_valid", 32'(l_valid), 32'd0);
    beat(0, 0, 0, 0);
    beat(0, 0, 1, 32'd42);
    check("t6_keep", 32'(r_cnt), 32'd1);
    beat(0, 0, 1, 32'd43);
    check("t6_drop", 32'(r_cnt), 32'd1);
    beat(1, 32'd1, 0, 0);
    check("t6_pair_r", r_pxl, 32'd43);
    check("t6_pair_l", l_pxl, 32'd43);
    check("t6_empty", 32'(l_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
